// File: rtl/reg_arb_pkg.sv
// Shared types for the register-file write-port arbiter.
//   arb_state_t : INIT (post-reset clear sweep) / RUN (normal arbitration)
//   src_t       : writeback source identifier, M (load) or A (ALU)
//   RR_RESET    : round-robin pointer value after reset (loads win the first tie)
package reg_arb_pkg;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} arb_state_t;

  typedef enum logic {SRC_M = 1'b0, SRC_A = 1'b1} src_t;

  localparam src_t RR_RESET = SRC_M;

endpackage

// File: rtl/reg_wr_skid.sv
// One-entry holding buffer for a single writeback source.
// Ports:
//   clk, rst_n    : clock and synchronous active-low reset (clears valid only)
//   en            : buffer may accept (arbiter in RUN and out of reset)
//   in_valid      : source request
//   in_ready      : en & (empty | entry popped this cycle)
//   in_addr/data  : source destination register and value
//   pop           : entry granted the write port this cycle
//   out_valid     : entry held
//   out_addr/data : held entry fields
//   accept        : in_valid & in_ready, used by the arbiter for age tracking
module reg_wr_skid #(
  parameter int pw = 3,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [pw-1:0] in_addr,
  input  logic [DW-1:0] in_data,
  input  logic          pop,
  output logic          out_valid,
  output logic [pw-1:0] out_addr,
  output logic [DW-1:0] out_data,
  output logic          accept
);

  logic          vld_p0;
  logic [pw-1:0] addr_p0;
  logic [DW-1:0] data_p0;

  // Refill in the same cycle the entry drains gives one accept per cycle.
  assign in_ready  = en & (~vld_p0 | pop);
  assign accept    = in_valid & in_ready;
  assign out_valid = vld_p0;
  assign out_addr  = addr_p0;
  assign out_data  = data_p0;

  always_ff @(posedge clk) begin
    if (!rst_n)      vld_p0 <= 1'b0;
    else if (accept) vld_p0 <= 1'b1;
    else if (pop)    vld_p0 <= 1'b0;
  end

  // Stage p0: captured entry (payload carries no reset)
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p0 <= in_addr;
      data_p0 <= in_data;
    end
  end

endmodule

// File: rtl/reg_wr_arbiter.sv
// Shares the register file's single write port between the ALU writeback (A)
// and the load writeback (M). Each source has a one-entry buffer. The older
// buffered entry is written first; entries accepted on the same edge are
// ordered by a round-robin pointer that flips after every tie grant. After
// reset every register is swept to zero before requests are accepted.
// Ports:
//   clk, rst_n              : clock, synchronous active-low reset
//   a_valid/a_ready/a_addr/a_data : ALU writeback request handshake
//   m_valid/m_ready/m_addr/m_data : load writeback request handshake
//   wr_en/wr_addr/dat_out   : register file write port
//   init_busy               : high while the clear sweep runs (and in reset)
module reg_wr_arbiter
  import reg_arb_pkg::*;
#(
  parameter int pw = 3,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [pw-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  input  logic          m_valid,
  output logic          m_ready,
  input  logic [pw-1:0] m_addr,
  input  logic [DW-1:0] m_data,
  output logic          wr_en,
  output logic [pw-1:0] wr_addr,
  output logic [DW-1:0] dat_out,
  output logic          init_busy
);

  arb_state_t    state_q, state_d;
  logic [pw-1:0] cnt_q, cnt_d;
  src_t          rr_q;
  src_t          older_q;
  logic          tie_q;

  logic          run;
  logic          a_v, m_v, a_acc, m_acc;
  logic [pw-1:0] a_baddr, m_baddr;
  logic [DW-1:0] a_bdata, m_bdata;
  logic          gnt_a, gnt_m;
  src_t          sel;

  // Gating with rst_n keeps the handshakes closed during the reset cycle itself.
  assign run = rst_n & (state_q == RUN);

  reg_wr_skid #(.pw(pw), .DW(DW)) u_skid_a (
    .clk(clk), .rst_n(rst_n), .en(run),
    .in_valid(a_valid), .in_ready(a_ready), .in_addr(a_addr), .in_data(a_data),
    .pop(gnt_a), .out_valid(a_v), .out_addr(a_baddr), .out_data(a_bdata),
    .accept(a_acc)
  );

  reg_wr_skid #(.pw(pw), .DW(DW)) u_skid_m (
    .clk(clk), .rst_n(rst_n), .en(run),
    .in_valid(m_valid), .in_ready(m_ready), .in_addr(m_addr), .in_data(m_data),
    .pop(gnt_m), .out_valid(m_v), .out_addr(m_baddr), .out_data(m_bdata),
    .accept(m_acc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + pw'(1);
      if (cnt_q == '1) state_d = RUN;
    end
  end

  // Grant: with both entries held, the age bit decides unless they arrived
  // on the same edge, in which case the round-robin pointer decides.
  always_comb begin
    gnt_a = 1'b0;
    gnt_m = 1'b0;
    sel   = tie_q ? rr_q : older_q;
    if (run) begin
      if (a_v && m_v) begin
        gnt_a = (sel == SRC_A);
        gnt_m = (sel == SRC_M);
      end else begin
        gnt_a = a_v;
        gnt_m = m_v;
      end
    end
  end

  always_comb begin
    wr_en     = 1'b0;
    wr_addr   = '0;
    dat_out   = '0;
    init_busy = 1'b1;
    if (rst_n) begin
      if (state_q == INIT) begin
        wr_en   = 1'b1;
        wr_addr = cnt_q;
      end else begin
        init_busy = 1'b0;
        if (gnt_a) begin
          wr_en   = 1'b1;
          wr_addr = a_baddr;
          dat_out = a_bdata;
        end else if (gnt_m) begin
          wr_en   = 1'b1;
          wr_addr = m_baddr;
          dat_out = m_bdata;
        end
      end
    end
  end

  // Age tracking: a lone acceptance makes the other source's entry (if it
  // stays) the older one; a same-edge acceptance of both marks a tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q    <= RR_RESET;
      older_q <= SRC_M;
      tie_q   <= 1'b0;
    end else begin
      if (a_v && m_v && tie_q && (gnt_a || gnt_m))
        rr_q <= (rr_q == SRC_A) ? SRC_M : SRC_A;
      if (a_acc && m_acc) begin
        tie_q <= 1'b1;
      end else if (a_acc) begin
        tie_q   <= 1'b0;
        older_q <= SRC_M;
      end else if (m_acc) begin
        tie_q   <= 1'b0;
        older_q <= SRC_A;
      end
    end
  end

endmodule
